// File: rtl/req_encoder_32_5_if.sv
// Request/handshake bundle for the 32-to-5 request encoder.
// slave = encoder side, master = request source / index consumer side.
interface req_encoder_32_5_if;
  logic [31:0] req_in;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic [31:0] out_onehot;
  logic [31:0] pending;
  logic        busy;

  modport slave (
    input  req_in,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_onehot,
    output pending,
    output busy
  );

  modport master (
    output req_in,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_onehot,
    input  pending,
    input  busy
  );
endinterface

// File: rtl/req_encoder_32_5.sv
// Latches single-cycle request strobes into a pending vector and serves them
// one at a time as a 5-bit index over valid/ready, fixed or round-robin priority.
module req_encoder_32_5 #(
  parameter bit RR_EN = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  req_encoder_32_5_if.slave  bus
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_valid;
  logic [4:0]  r_idx;
  logic [4:0]  r_last;
  logic [31:0] r_pending;

  logic        w_accept;
  logic [31:0] w_idx_onehot;
  logic [31:0] w_clr;
  logic [31:0] w_cand;
  logic [4:0]  w_base;
  logic [4:0]  w_pos;
  logic [4:0]  w_sel;
  logic        w_found;

  always_comb begin
    w_accept     = r_valid & bus.out_ready;
    w_idx_onehot = 32'd1 << r_idx;
    w_clr        = w_accept ? w_idx_onehot : '0;
    w_cand       = r_pending & ~(r_valid ? w_idx_onehot : '0);

    // On an accept the presented index becomes the last served one, so the
    // scan starts just after it rather than after the stale pointer.
    if (!RR_EN)
      w_base = '0;
    else if (r_valid)
      w_base = r_idx + 5'd1;
    else
      w_base = r_last + 5'd1;

    w_pos   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < 32; k++) begin
      w_pos = w_base + k[4:0];
      if (!w_found && w_cand[w_pos]) begin
        w_sel   = w_pos;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_last    <= 5'd31;
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | bus.req_in;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_idx   <= w_sel;
            r_valid <= 1'b1;
            r_state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (bus.out_ready) begin
            r_last <= r_idx;
            if (w_found) begin
              r_idx <= w_sel;
            end else begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.out_idx    = r_idx;
  assign bus.pending    = r_pending;
  assign bus.out_onehot = r_valid ? w_idx_onehot : '0;
  assign bus.busy       = r_valid | (|r_pending);

endmodule

// File: tb/tb_req_encoder_32_5.sv
// Bench for req_encoder_32_5: fixed-priority and round-robin instances share
// stimulus and are each compared every cycle against a behavioural model.
module tb_req_encoder_32_5;

  logic clock = 1'b0;
  logic reset = 1'b0;

  req_encoder_32_5_if ifc0 ();
  req_encoder_32_5_if ifc1 ();

  req_encoder_32_5 #(.RR_EN(1'b0)) dut_fix (
    .clock (clock),
    .reset (reset),
    .bus   (ifc0.slave)
  );

  req_encoder_32_5 #(.RR_EN(1'b1)) dut_rr (
    .clock (clock),
    .reset (reset),
    .bus   (ifc1.slave)
  );

  always #5 clock = ~clock;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [31:0] t_req = '0;
  logic        t_rdy = 1'b0;

  // Reference model, index 0 = fixed priority, index 1 = round robin.
  bit [31:0] m_pend  [2];
  bit        m_valid [2];
  int        m_idx   [2];
  int        m_last  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        m_pend[d]  = '0;
        m_valid[d] = 1'b0;
        m_idx[d]   = 0;
        m_last[d]  = 31;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit        acc;
        int        old_idx;
        int        start;
        bit        found;
        int        pick;
        bit [31:0] nxt;
        acc     = m_valid[d] && t_rdy;
        old_idx = m_idx[d];
        if (!m_valid[d] || t_rdy) begin
          if (m_valid[d]) m_last[d] = old_idx;
          start = (d == 1) ? (m_last[d] + 1) % 32 : 0;
          found = 1'b0;
          pick  = 0;
          for (int k = 0; k < 32; k++) begin
            int p;
            p = (start + k) % 32;
            if (!found && m_pend[d][p] && !(m_valid[d] && p == old_idx)) begin
              found = 1'b1;
              pick  = p;
            end
          end
          if (found) m_idx[d] = pick;
          m_valid[d] = found;
        end
        nxt = m_pend[d];
        if (acc) nxt[old_idx] = 1'b0;
        m_pend[d] = nxt | t_req;
      end
    end
  end

  task automatic drive(input logic [31:0] req, input logic rdy);
    t_req          = req;
    t_rdy          = rdy;
    ifc0.req_in    = req;
    ifc0.out_ready = rdy;
    ifc1.req_in    = req;
    ifc1.out_ready = rdy;
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] exp_oh;
    for (int d = 0; d < 2; d++) begin
      logic        v;
      logic [4:0]  ix;
      logic [31:0] oh;
      logic [31:0] pd;
      logic        bz;
      if (d == 0) begin
        v = ifc0.out_valid; ix = ifc0.out_idx; oh = ifc0.out_onehot; pd = ifc0.pending; bz = ifc0.busy;
      end else begin
        v = ifc1.out_valid; ix = ifc1.out_idx; oh = ifc1.out_onehot; pd = ifc1.pending; bz = ifc1.busy;
      end
      exp_oh = m_valid[d] ? (32'd1 << m_idx[d]) : 32'd0;
      chk($sformatf("%s.d%0d.valid", tag, d), {31'd0, v}, {31'd0, m_valid[d]});
      if (m_valid[d])
        chk($sformatf("%s.d%0d.idx", tag, d), {27'd0, ix}, m_idx[d]);
      chk($sformatf("%s.d%0d.onehot", tag, d), oh, exp_oh);
      chk($sformatf("%s.d%0d.pending", tag, d), pd, m_pend[d]);
      chk($sformatf("%s.d%0d.busy", tag, d), {31'd0, bz},
          {31'd0, (m_valid[d] || m_pend[d] != 0)});
    end
  endtask

  // Called at a negedge: drive, cross one active edge, sample at next negedge.
  task automatic step(input string tag, input logic [31:0] req, input logic rdy);
    drive(req, rdy);
    @(posedge clock);
    @(negedge clock);
    compare_all(tag);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    drive('1, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst.valid", {31'd0, ifc0.out_valid}, 32'd0);
    chk("rst.pending", ifc0.pending, 32'd0);
    chk("rst.busy", {31'd0, ifc1.busy}, 32'd0);
    compare_all("rst");
    drive('0, 1'b0);
    reset = 1'b1;
    step("idle0", 32'd0, 1'b1);
    chk("idle0.valid", {31'd0, ifc0.out_valid}, 32'd0);

    // single request
    step("single.a", 32'h0000_0400, 1'b1);
    step("single.b", 32'd0, 1'b1);
    chk("single.valid", {31'd0, ifc0.out_valid}, 32'd1);
    chk("single.idx", {27'd0, ifc0.out_idx}, 32'd10);
    chk("single.onehot", ifc0.out_onehot, 32'h0000_0400);
    step("single.c", 32'd0, 1'b1);
    chk("single.pend0", ifc0.pending, 32'd0);
    chk("single.busy0", {31'd0, ifc0.busy}, 32'd0);

    // fixed priority with backpressure
    step("fix.set", 32'h8000_0011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("fix.hold", 32'd0, 1'b0);
      chk("fix.hold.idx", {27'd0, ifc0.out_idx}, 32'd0);
      chk("fix.hold.valid", {31'd0, ifc0.out_valid}, 32'd1);
    end
    step("fix.s1", 32'd0, 1'b1);
    chk("fix.idx4", {27'd0, ifc0.out_idx}, 32'd4);
    step("fix.s2", 32'd0, 1'b1);
    chk("fix.idx31", {27'd0, ifc0.out_idx}, 32'd31);
    step("fix.s3", 32'd0, 1'b1);
    chk("fix.idle", {31'd0, ifc0.out_valid}, 32'd0);

    // round robin ordering
    pulse_reset();
    step("rr.a", 32'h0000_0020, 1'b1);
    step("rr.b", 32'd0, 1'b1);
    chk("rr.first5", {27'd0, ifc1.out_idx}, 32'd5);
    step("rr.c", 32'd0, 1'b1);
    step("rr.d", 32'h0000_0021, 1'b1);
    step("rr.e", 32'd0, 1'b1);
    chk("rr.wrap0", {27'd0, ifc1.out_idx}, 32'd0);
    step("rr.f", 32'd0, 1'b1);
    chk("rr.then5", {27'd0, ifc1.out_idx}, 32'd5);
    step("rr.g", 32'd0, 1'b1);
    step("rr.h", 32'h8000_0001, 1'b1);
    step("rr.i", 32'd0, 1'b1);
    chk("rr.idx31", {27'd0, ifc1.out_idx}, 32'd31);
    chk("rr.fix0", {27'd0, ifc0.out_idx}, 32'd0);
    step("rr.j", 32'd0, 1'b1);
    chk("rr.idx0", {27'd0, ifc1.out_idx}, 32'd0);
    step("rr.k", 32'd0, 1'b1);

    // set/clear collision
    pulse_reset();
    step("col.a", 32'h0000_0080, 1'b1);
    step("col.b", 32'd0, 1'b1);
    chk("col.idx7", {27'd0, ifc0.out_idx}, 32'd7);
    step("col.c", 32'h0000_0080, 1'b1);
    chk("col.pend7", ifc0.pending, 32'h0000_0080);
    step("col.d", 32'd0, 1'b1);
    chk("col.again7", {27'd0, ifc0.out_idx}, 32'd7);
    chk("col.again.valid", {31'd0, ifc1.out_valid}, 32'd1);
    step("col.e", 32'd0, 1'b1);

    // reset mid-operation, asserted between edges
    pulse_reset();
    step("mid.a", 32'h0000_00F0, 1'b0);
    step("mid.b", 32'd0, 1'b0);
    chk("mid.pend", ifc0.pending, 32'h0000_00F0);
    chk("mid.valid", {31'd0, ifc0.out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid.rst.valid", {31'd0, ifc0.out_valid}, 32'd0);
    chk("mid.rst.pend", ifc0.pending, 32'd0);
    chk("mid.rst.onehot", ifc1.out_onehot, 32'd0);
    chk("mid.rst.busy", {31'd0, ifc1.busy}, 32'd0);
    compare_all("mid.rst");
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("mid.after", 32'd0, 1'b1);
      chk("mid.after.valid", {31'd0, ifc1.out_valid}, 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] r;
      logic        rd;
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = 32'd1 << $urandom_range(0, 31);
        2:       r = $urandom & $urandom & $urandom;
        default: r = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) r = '0;
      rd = ($urandom_range(0, 9) < 7);
      step("rand", r, rd);
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    // drain with ready held high
    for (int i = 0; i < 40; i++) step("drain", 32'd0, 1'b1);
    chk("drain.busy0", {31'd0, ifc0.busy}, 32'd0);
    chk("drain.busy1", {31'd0, ifc1.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
